// File: rtl/ptos_defs.sv
// Constants shared by the lane serializer and its matching deserializer:
// 8b/10b control symbols, default geometry and the word-select encoding.
package ptos_defs;

  localparam int WIDTH_DEF      = 8;
  localparam int COM_PERIOD_DEF = 4;

  localparam logic [7:0] K28_5_COM  = 8'hBC;
  localparam logic [7:0] K28_3_IDLE = 8'h7C;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_COM,
    SEL_DATA
  } sym_sel_e;

  // Counter width that stays legal for periods of 0 or 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ptos_symbol_mux.sv
// Chooses the word loaded into the shift register at a load slot and
// generates the COM-due and upstream ready indications.
module ptos_symbol_mux
  import ptos_defs::*;
#(
  parameter int               WIDTH      = WIDTH_DEF,
  parameter logic [WIDTH-1:0] IDLE_SYM   = WIDTH'(K28_3_IDLE),
  parameter logic [WIDTH-1:0] COM_SYM    = WIDTH'(K28_5_COM),
  parameter int               COM_PERIOD = COM_PERIOD_DEF,
  parameter int               COM_W      = cnt_width(COM_PERIOD)
) (
  input  logic             reset,
  input  logic             active,
  input  logic             valid_in,
  input  logic             load_slot,
  input  logic [COM_W-1:0] com_cnt,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] word,
  output logic             ready_out
);

  sym_sel_e sel;
  logic     com_due;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the if/case can leave one unassigned and infer a latch.
    sel     = SEL_IDLE;
    word    = IDLE_SYM;
    com_due = (COM_PERIOD != 0) && (com_cnt == '0);

    if (active) begin
      if (com_due)       sel = SEL_COM;
      else if (valid_in) sel = SEL_DATA;
    end

    unique case (sel)
      SEL_COM:  word = COM_SYM;
      SEL_DATA: word = data_in;
      default:  word = IDLE_SYM;
    endcase
  end

  // COM slots withhold ready so upstream keeps its word for the next slot.
  assign ready_out = reset && active && load_slot && !com_due;

endmodule

// File: rtl/ptos_lane_serializer.sv
// Parallel-to-serial lane serializer, MSB first, with IDLE fill and
// periodic COM insertion, all on the bit clock.
module ptos_lane_serializer
  import ptos_defs::*;
#(
  parameter int               WIDTH      = WIDTH_DEF,
  parameter logic [WIDTH-1:0] IDLE_SYM   = WIDTH'(K28_3_IDLE),
  parameter logic [WIDTH-1:0] COM_SYM    = WIDTH'(K28_5_COM),
  parameter int               COM_PERIOD = COM_PERIOD_DEF
) (
  input  logic             clk32f,
  input  logic             reset,
  input  logic             active,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             out,
  output logic             word_start
);

  localparam int               BIT_W    = $clog2(WIDTH);
  localparam int               COM_W    = cnt_width(COM_PERIOD);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [COM_W-1:0] COM_LAST = COM_W'((COM_PERIOD > 1) ? COM_PERIOD - 1 : 0);

  logic [WIDTH-1:0] shreg;
  logic [BIT_W-1:0] bit_cnt;
  logic [COM_W-1:0] com_cnt;
  logic             loaded;
  logic             load_slot;
  logic [WIDTH-1:0] next_word;

  assign load_slot = (bit_cnt == BIT_LAST);

  ptos_symbol_mux #(
    .WIDTH      (WIDTH),
    .IDLE_SYM   (IDLE_SYM),
    .COM_SYM    (COM_SYM),
    .COM_PERIOD (COM_PERIOD),
    .COM_W      (COM_W)
  ) u_mux (
    .reset     (reset),
    .active    (active),
    .valid_in  (valid_in),
    .load_slot (load_slot),
    .com_cnt   (com_cnt),
    .data_in   (data_in),
    .word      (next_word),
    .ready_out (ready_out)
  );

  always_ff @(posedge clk32f) begin
    // NOTE: non-blocking assignments so every register samples pre-edge
    // values regardless of statement order.
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= BIT_LAST;
      com_cnt <= '0;
      loaded  <= 1'b0;
    end else if (load_slot) begin
      shreg   <= next_word;
      bit_cnt <= '0;
      loaded  <= 1'b1;
      // An inactive lane restarts the COM interval so re-activation leads with COM.
      if (!active || com_cnt == COM_LAST) com_cnt <= '0;
      else                                com_cnt <= com_cnt + COM_W'(1);
    end else begin
      shreg   <= {shreg[WIDTH-2:0], 1'b0};
      bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  assign out        = shreg[WIDTH-1];
  assign word_start = loaded && (bit_cnt == '0);

endmodule

// File: tb/tb_ptos_lane_serializer.sv
// Scoreboard bench for ptos_lane_serializer: expected line words are queued
// per scenario and compared as the serial monitor reassembles them.
module tb_ptos_lane_serializer;

  localparam int         W    = 8;
  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;

  logic         clk32f   = 1'b0;
  logic         reset    = 1'b0;
  logic         active   = 1'b0;
  logic [W-1:0] data_in  = '0;
  logic         valid_in = 1'b0;
  logic         ready_out;
  logic         out;
  logic         word_start;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb[$];
  logic         mon_en = 1'b0;
  string        cur_test = "none";

  ptos_lane_serializer #(
    .WIDTH      (W),
    .IDLE_SYM   (IDLE),
    .COM_SYM    (COM),
    .COM_PERIOD (4)
  ) dut (
    .clk32f     (clk32f),
    .reset      (reset),
    .active     (active),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .out        (out),
    .word_start (word_start)
  );

  always #5 clk32f = ~clk32f;

  // Serial monitor: rebuilds words from word_start/out and pops the scoreboard.
  int           nbits   = 0;
  logic         started = 1'b0;
  logic [W-1:0] rx      = '0;
  logic [W-1:0] exp_w;

  always @(negedge clk32f) begin
    if (!mon_en) begin
      nbits   = 0;
      started = 1'b0;
    end else begin
      if (word_start && nbits != 0) begin
        checks++;
        errors++;
        $display("FAIL %s word_start: high after %0d bits, required after %0d", cur_test, nbits, W);
      end
      if (started && nbits == 0 && !word_start) begin
        checks++;
        errors++;
        $display("FAIL %s gap: word_start low, required high for next word", cur_test);
      end
      if (word_start) begin
        started = 1'b1;
        nbits   = 1;
        rx      = {{(W-1){1'b0}}, out};
      end else if (started) begin
        rx    = {rx[W-2:0], out};
        nbits = nbits + 1;
      end
      if (nbits == W) begin
        nbits = 0;
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          checks++;
          if (rx !== exp_w) begin
            errors++;
            $display("FAIL %s word: got %h, required %h", cur_test, rx, exp_w);
          end
        end
      end
    end
  end

  // Holds reset low 5 cycles checking quiet outputs, then releases it.
  task automatic do_reset();
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk32f);
      checks++;
      if ({out, word_start, ready_out} !== 3'b000) begin
        errors++;
        $display("FAIL %s reset_outputs: out/word_start/ready_out=%b, required 000",
                 cur_test, {out, word_start, ready_out});
      end
    end
    reset = 1'b1;
    #1;
  endtask

  task automatic start_test(input string name);
    cur_test = name;
    mon_en   = 1'b0;
    sb.delete();
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(negedge clk32f);
      c++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d words outstanding, required 0", cur_test, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    start_test("reset_idle");
    active   = 1'b0;
    valid_in = 1'b0;
    do_reset();
    mon_en = 1'b1;
    repeat (3) sb.push_back(IDLE);
    wait_drain(60);
  endtask

  task automatic test_com_first();
    start_test("com_first");
    active   = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'hA5;
    do_reset();
    mon_en = 1'b1;
    sb.push_back(COM);
    sb.push_back(8'hA5);
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_first_slot: got %b, required 0", cur_test, ready_out);
    end
    repeat (8) @(negedge clk32f);
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_second_slot: got %b, required 1", cur_test, ready_out);
    end
    wait_drain(40);
  endtask

  task automatic test_back_to_back();
    int   idx     = 0;
    int   cyc     = 0;
    logic pending = 1'b0;
    start_test("back_to_back");
    active   = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h01;
    do_reset();
    mon_en = 1'b1;
    foreach (sb[i]) sb.delete(i);
    sb.push_back(COM);
    sb.push_back(8'h01);
    sb.push_back(8'h02);
    sb.push_back(8'h03);
    sb.push_back(COM);
    sb.push_back(8'h04);
    sb.push_back(8'h05);
    while (idx < 5 && cyc < 200) begin
      if (pending) begin
        idx++;
        if (idx < 5) data_in = W'(idx + 1);
        else         valid_in = 1'b0;
      end
      pending = valid_in && ready_out;
      if (idx < 5) begin
        @(negedge clk32f);
        cyc++;
      end
    end
    checks++;
    if (idx != 5) begin
      errors++;
      $display("FAIL %s handshake: %0d words accepted, required 5", cur_test, idx);
      valid_in = 1'b0;
    end
    wait_drain(60);
  endtask

  task automatic test_idle_fill();
    int rdy = 0;
    start_test("idle_fill");
    active   = 1'b1;
    valid_in = 1'b0;
    do_reset();
    mon_en = 1'b1;
    sb.push_back(COM);
    repeat (3) sb.push_back(IDLE);
    sb.push_back(COM);
    repeat (39) begin
      @(negedge clk32f);
      if (ready_out) rdy++;
    end
    checks++;
    if (rdy != 3) begin
      errors++;
      $display("FAIL %s ready_pulses: got %0d, required 3", cur_test, rdy);
    end
    wait_drain(20);
  endtask

  task automatic test_active_drop();
    start_test("active_drop");
    active   = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h96;
    do_reset();
    mon_en = 1'b1;
    sb.push_back(COM);
    sb.push_back(8'h96);
    sb.push_back(IDLE);
    sb.push_back(COM);
    sb.push_back(IDLE);
    repeat (12) @(negedge clk32f);
    active   = 1'b0;
    valid_in = 1'b0;
    repeat (8) @(negedge clk32f);
    active = 1'b1;
    wait_drain(60);
  endtask

  task automatic test_reset_mid_word();
    start_test("reset_mid_word");
    active   = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h5A;
    do_reset();
    mon_en = 1'b1;
    sb.push_back(COM);
    repeat (12) @(negedge clk32f);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s com_before_reset: %0d words outstanding, required 0", cur_test, sb.size());
    end
    mon_en   = 1'b0;
    active   = 1'b0;
    valid_in = 1'b0;
    sb.delete();
    do_reset();
    mon_en = 1'b1;
    sb.push_back(IDLE);
    sb.push_back(IDLE);
    wait_drain(40);
  endtask

  initial begin
    test_reset();
    test_com_first();
    test_back_to_back();
    test_idle_fill();
    test_active_drop();
    test_reset_mid_word();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
